cdb_writeback_arbiter: RTL and testbench
========================================

Name: cdb_writeback_arbiter

Overview:
- Drives the common data bus (CDB) that reservation stations, the ROB and the physical register file snoop for operand wakeup and completion.
- Accepts completed results from NUM_FU functional units through valid/ready handshakes and buffers them in a small per-FU FIFO.
- Each cycle, grants up to CDB_W results using a rotating round-robin priority, and broadcasts them on registered CDB outputs.
- Per-lane output format matches the RS wakeup interface: valid, physical tag, 64-bit value, ROB tag.

Parameters:
NUM_FU, 4, number of functional-unit result sources
CDB_W, 2, number of CDB broadcast lanes per cycle
PHYS_W, 6, physical register tag width
ROB_W, 6, ROB tag width
FIFO_DEPTH, 2, per-FU result buffer depth (power of two, >=2)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
flush  input  1  pipeline flush: discard all buffered and pending results
fu_valid  input  NUM_FU  FU i presents a result
fu_ready  output  NUM_FU  FU i result accepted this cycle if fu_valid[i]
fu_tag  input  NUM_FU x PHYS_W  destination physical tag per FU
fu_value  input  NUM_FU x 64  result value per FU
fu_rob_tag  input  NUM_FU x ROB_W  ROB tag per FU
cdb_valid  output  CDB_W  lane broadcast valid
cdb_tag  output  CDB_W x PHYS_W  broadcast physical tag
cdb_value  output  CDB_W x 64  broadcast value
cdb_rob_tag  output  CDB_W x ROB_W  broadcast ROB tag

Behaviour:
- Clock and reset: clock clk; reset is asynchronous and active-high.
- Reset state: all FIFOs empty, rr_ptr=0, and all cdb_* outputs are 0.
- fu_ready[i] = !full[i] && !flush.
  - Derived only from the registered FIFO count; it does not depend on fu_valid or on the same-cycle pop.
  - A full FIFO does not accept a new result even in a cycle where it pops.
- Push: when fu_valid[i] && fu_ready[i] at a rising edge, {tag, value, rob_tag} is written to FIFO i. Results from one FU stay in order.
- Arbitration (combinational, on registered FIFO state):
  - Scan FU indices rr_ptr, rr_ptr+1, ... mod NUM_FU.
  - The first CDB_W non-empty FIFOs are granted, at most one grant per FU per cycle.
  - The k-th grant in scan order goes to CDB lane k.
- Pop: each granted FIFO head is popped at the same edge that loads the output registers.
- rr_ptr update:
  - With at least one grant: rr_ptr <= (index of last granted FU + 1) mod NUM_FU.
  - With no grant: rr_ptr is unchanged.
- Outputs: cdb_* are registered.
  - Lane k with a grant: cdb_valid[k]=1 and the payload equals the granted head.
  - Lanes without a grant: cdb_valid=0 and all payload fields are driven to 0.
  - Each broadcast lasts exactly one cycle; there is no backpressure from the CDB.
- Latency: a result accepted at edge t is broadcast at the earliest after edge t+1, i.e. 2 cycles. There is no bypass from input to CDB.
- Occupancy: the FIFO count updates push and pop in the same cycle (count unchanged if both occur). Pointers wrap modulo FIFO_DEPTH.
- Flush (synchronous, highest priority):
  - At the edge where flush=1, all FIFOs are emptied, rr_ptr is set to 0, and all cdb_valid bits clear.
  - No pushes occur during a flush cycle because fu_ready is held at 0.
  - A broadcast already registered before the flush edge remains visible for its one cycle.
- Reset mid-operation: all buffered results are dropped immediately and outputs go to 0 asynchronously.
- Values and tags are passed through unmodified. Tag 0 has no special meaning.

Test Plan:
1. Single result: FU1 presents tag=0x05, value=0xDEAD_BEEF, rob=3, accepted at edge 1.
   -> cdb_valid=2'b01 after edge 2, lane0={5, 0xDEADBEEF, 3}; idle after edge 3.
2. Contention with rr_ptr=0: all 4 FUs push simultaneously with tags 10,11,12,13.
   -> Cycle A: lane0=10, lane1=11, rr_ptr=2.
   -> Next cycle: lane0=12, lane1=13, rr_ptr=0.
3. Fairness/wrap: FU3 and FU0 continuously supply results with rr_ptr=3.
   -> Grant order is FU3 on lane0, FU0 on lane1.
   -> rr_ptr becomes 1 and broadcasts alternate with no starvation.
4. Backpressure: FU2 pushes 3 results on consecutive cycles while FIFO 2 holds 2 entries and all lanes are busy with FU0/FU1 streams.
   -> fu_ready[2]=0 when count=2.
   -> The third result is held at the input and accepted only after a pop; in-order tags are preserved.
5. Flush: FIFOs hold 3 results and flush is asserted for 1 cycle.
   -> fu_ready=0 during the flush cycle; all cdb_valid=0 after the flush edge.
   -> No stale tags appear afterwards; a new push broadcasts after 2 cycles.
6. Reset mid-stream: reset is asserted asynchronously while cdb_valid=2'b11.
   -> Outputs go to 0 immediately.
   -> After deassert, no previously buffered result ever appears on the CDB.

Source files
------------

// File: rtl/cdb_writeback_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_writeback_arbiter
// Collects completed results from NUM_FU functional units into small per-FU
// FIFOs and broadcasts up to CDB_W of them per cycle on the common data bus.
// Lane selection is rotating round-robin starting at r_rr_ptr. The k-th grant
// in scan order drives lane k. All CDB outputs are registered.
//
// Ports:
//   clk            clock
//   reset          asynchronous, active-high reset
//   i_flush        synchronous flush: drop every buffered result, rr_ptr <= 0
//   i_fu_valid     per-FU result valid
//   o_fu_ready     per-FU accept (FIFO not full and no flush)
//   i_fu_tag       per-FU destination physical tag
//   i_fu_value     per-FU 64-bit result value
//   i_fu_rob_tag   per-FU ROB tag
//   o_cdb_valid    per-lane broadcast valid
//   o_cdb_tag      per-lane physical tag (0 when lane idle)
//   o_cdb_value    per-lane value (0 when lane idle)
//   o_cdb_rob_tag  per-lane ROB tag (0 when lane idle)
// -----------------------------------------------------------------------------
module cdb_writeback_arbiter #(
  parameter int NUM_FU     = 4,
  parameter int CDB_W      = 2,
  parameter int PHYS_W     = 6,
  parameter int ROB_W      = 6,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           i_flush,
  input  logic [NUM_FU-1:0]              i_fu_valid,
  output logic [NUM_FU-1:0]              o_fu_ready,
  input  logic [NUM_FU-1:0][PHYS_W-1:0]  i_fu_tag,
  input  logic [NUM_FU-1:0][63:0]        i_fu_value,
  input  logic [NUM_FU-1:0][ROB_W-1:0]   i_fu_rob_tag,
  output logic [CDB_W-1:0]               o_cdb_valid,
  output logic [CDB_W-1:0][PHYS_W-1:0]   o_cdb_tag,
  output logic [CDB_W-1:0][63:0]         o_cdb_value,
  output logic [CDB_W-1:0][ROB_W-1:0]    o_cdb_rob_tag
);

  localparam int FU_W   = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int LANE_W = $clog2(CDB_W + 1);

  // Per-FU result storage (data only, no reset needed: validity lives in r_count)
  logic [PHYS_W-1:0] r_tag_mem [NUM_FU][FIFO_DEPTH];
  logic [63:0]       r_val_mem [NUM_FU][FIFO_DEPTH];
  logic [ROB_W-1:0]  r_rob_mem [NUM_FU][FIFO_DEPTH];

  logic [PTR_W-1:0]  r_rd_ptr [NUM_FU];
  logic [PTR_W-1:0]  r_wr_ptr [NUM_FU];
  logic [CNT_W-1:0]  r_count  [NUM_FU];
  logic [FU_W-1:0]   r_rr_ptr;

  logic [NUM_FU-1:0] w_full;
  logic [NUM_FU-1:0] w_empty;
  logic [NUM_FU-1:0] w_push;
  logic [NUM_FU-1:0] w_grant;
  logic [CDB_W-1:0]  w_lane_vld;
  logic [FU_W-1:0]   w_lane_src [CDB_W];
  logic [FU_W-1:0]   w_rr_nxt;
  logic [PHYS_W-1:0] w_head_tag [CDB_W];
  logic [63:0]       w_head_val [CDB_W];
  logic [ROB_W-1:0]  w_head_rob [CDB_W];

  // Next FU index after idx, wrapping at NUM_FU (NUM_FU need not be a power of two)
  function automatic logic [FU_W-1:0] fu_inc(input logic [FU_W-1:0] idx);
    return (idx == FU_W'(NUM_FU - 1)) ? {FU_W{1'b0}} : idx + FU_W'(1);
  endfunction

  // FIFO status and input handshake, all from registered occupancy
  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      w_full[i]  = (r_count[i] == CNT_W'(FIFO_DEPTH));
      w_empty[i] = (r_count[i] == {CNT_W{1'b0}});
    end
    o_fu_ready = ~w_full & {NUM_FU{~i_flush}};
    w_push     = i_fu_valid & o_fu_ready;
  end

  // Round-robin scan from r_rr_ptr: first CDB_W non-empty FIFOs win, in lane order
  always_comb begin
    logic [FU_W:0]     v_sum;
    logic [FU_W-1:0]   v_idx;
    logic [LANE_W-1:0] v_n;
    logic              v_take;
    w_grant    = {NUM_FU{1'b0}};
    w_lane_vld = {CDB_W{1'b0}};
    w_rr_nxt   = r_rr_ptr;
    v_n        = {LANE_W{1'b0}};
    v_sum      = {(FU_W+1){1'b0}};
    v_idx      = {FU_W{1'b0}};
    v_take     = 1'b0;
    for (int l = 0; l < CDB_W; l++) begin
      w_lane_src[l] = {FU_W{1'b0}};
    end
    for (int k = 0; k < NUM_FU; k++) begin
      v_sum  = {1'b0, r_rr_ptr} + (FU_W+1)'(k);
      v_sum  = (v_sum >= (FU_W+1)'(NUM_FU)) ? v_sum - (FU_W+1)'(NUM_FU) : v_sum;
      v_idx  = v_sum[FU_W-1:0];
      v_take = ~w_empty[v_idx] & (v_n < LANE_W'(CDB_W));
      w_grant[v_idx] = w_grant[v_idx] | v_take;
      for (int l = 0; l < CDB_W; l++) begin
        w_lane_vld[l] = w_lane_vld[l] | (v_take & (v_n == LANE_W'(l)));
        w_lane_src[l] = (v_take && (v_n == LANE_W'(l))) ? v_idx : w_lane_src[l];
      end
      w_rr_nxt = v_take ? fu_inc(v_idx) : w_rr_nxt;
      v_n      = v_n + LANE_W'(v_take);
    end
  end

  // Head-of-FIFO payload for each lane's granted source
  always_comb begin
    for (int l = 0; l < CDB_W; l++) begin
      w_head_tag[l] = r_tag_mem[w_lane_src[l]][r_rd_ptr[w_lane_src[l]]];
      w_head_val[l] = r_val_mem[w_lane_src[l]][r_rd_ptr[w_lane_src[l]]];
      w_head_rob[l] = r_rob_mem[w_lane_src[l]][r_rd_ptr[w_lane_src[l]]];
    end
  end

  // FIFO data write on accepted push
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (w_push[i]) begin
        r_tag_mem[i][r_wr_ptr[i]] <= i_fu_tag[i];
        r_val_mem[i][r_wr_ptr[i]] <= i_fu_value[i];
        r_rob_mem[i][r_wr_ptr[i]] <= i_fu_rob_tag[i];
      end
    end
  end

  // FIFO pointers/occupancy, round-robin pointer and registered CDB lanes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_FU; i++) begin
        r_rd_ptr[i] <= {PTR_W{1'b0}};
        r_wr_ptr[i] <= {PTR_W{1'b0}};
        r_count[i]  <= {CNT_W{1'b0}};
      end
      r_rr_ptr      <= {FU_W{1'b0}};
      o_cdb_valid   <= {CDB_W{1'b0}};
      o_cdb_tag     <= {(CDB_W*PHYS_W){1'b0}};
      o_cdb_value   <= {(CDB_W*64){1'b0}};
      o_cdb_rob_tag <= {(CDB_W*ROB_W){1'b0}};
    end else if (i_flush) begin
      // Flush wins over any pop/grant in the same cycle
      for (int i = 0; i < NUM_FU; i++) begin
        r_rd_ptr[i] <= {PTR_W{1'b0}};
        r_wr_ptr[i] <= {PTR_W{1'b0}};
        r_count[i]  <= {CNT_W{1'b0}};
      end
      r_rr_ptr      <= {FU_W{1'b0}};
      o_cdb_valid   <= {CDB_W{1'b0}};
      o_cdb_tag     <= {(CDB_W*PHYS_W){1'b0}};
      o_cdb_value   <= {(CDB_W*64){1'b0}};
      o_cdb_rob_tag <= {(CDB_W*ROB_W){1'b0}};
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        // Power-of-two depth: pointers wrap naturally
        r_wr_ptr[i] <= w_push[i]  ? r_wr_ptr[i] + PTR_W'(1) : r_wr_ptr[i];
        r_rd_ptr[i] <= w_grant[i] ? r_rd_ptr[i] + PTR_W'(1) : r_rd_ptr[i];
        case ({w_push[i], w_grant[i]})
          2'b10:   r_count[i] <= r_count[i] + CNT_W'(1);
          2'b01:   r_count[i] <= r_count[i] - CNT_W'(1);
          default: r_count[i] <= r_count[i];
        endcase
      end
      r_rr_ptr <= w_rr_nxt;
      for (int l = 0; l < CDB_W; l++) begin
        o_cdb_valid[l]   <= w_lane_vld[l];
        o_cdb_tag[l]     <= w_lane_vld[l] ? w_head_tag[l] : {PHYS_W{1'b0}};
        o_cdb_value[l]   <= w_lane_vld[l] ? w_head_val[l] : 64'd0;
        o_cdb_rob_tag[l] <= w_lane_vld[l] ? w_head_rob[l] : {ROB_W{1'b0}};
      end
    end
  end

endmodule

// File: tb/tb_cdb_writeback_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_writeback_arbiter
// Table-driven bench for cdb_writeback_arbiter (4 FUs, 2 lanes, depth 2).
// Each row gives inputs for one cycle, the expected fu_ready for that cycle
// and the expected lane valid/tags after the following rising edge. Every
// accepted result is also pushed to a per-FU expected queue; each broadcast
// pops its FU queue and must match tag, value and ROB tag in order.
// Value and ROB tag are derived from the tag so payload pass-through is checked.
// -----------------------------------------------------------------------------
module tb_cdb_writeback_arbiter;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic [3:0]       fu_valid;
  logic [3:0]       fu_ready;
  logic [3:0][5:0]  fu_tag;
  logic [3:0][63:0] fu_value;
  logic [3:0][5:0]  fu_rob;
  logic [1:0]       cdb_valid;
  logic [1:0][5:0]  cdb_tag;
  logic [1:0][63:0] cdb_value;
  logic [1:0][5:0]  cdb_rob;

  always #5 clk = ~clk;

  cdb_writeback_arbiter #(
    .NUM_FU(4), .CDB_W(2), .PHYS_W(6), .ROB_W(6), .FIFO_DEPTH(2)
  ) dut (
    .clk(clk), .reset(reset), .i_flush(flush),
    .i_fu_valid(fu_valid), .o_fu_ready(fu_ready),
    .i_fu_tag(fu_tag), .i_fu_value(fu_value), .i_fu_rob_tag(fu_rob),
    .o_cdb_valid(cdb_valid), .o_cdb_tag(cdb_tag),
    .o_cdb_value(cdb_value), .o_cdb_rob_tag(cdb_rob)
  );

  typedef struct packed {
    logic            fl;
    logic [3:0]      va;
    logic [3:0][5:0] tg;
    logic [3:0]      rd;
    logic [1:0]      cv;
    logic [5:0]      e0;
    logic [5:0]      e1;
  } vec_t;

  typedef struct packed {
    logic [5:0]  tag;
    logic [63:0] value;
    logic [5:0]  rob;
  } res_t;

  localparam int NV = 28;
  vec_t vecs [NV];
  res_t sb_q [4][$];
  int   fu_of [int];
  int   errs  = 0;
  int   n_chk = 0;

  function automatic logic [63:0] val_of(input logic [5:0] t);
    return {26'd0, t ^ 6'h05, 32'hDEAD_BEEF};
  endfunction

  function automatic logic [5:0] rob_of(input logic [5:0] t);
    return t ^ 6'h06;
  endfunction

  function automatic vec_t mk(input logic fl, input logic [3:0] va,
                              input int a, input int b, input int c, input int d,
                              input logic [3:0] rd, input logic [1:0] cv,
                              input int e0, input int e1);
    vec_t v;
    v.fl = fl; v.va = va; v.rd = rd; v.cv = cv;
    v.tg[0] = 6'(a); v.tg[1] = 6'(b); v.tg[2] = 6'(c); v.tg[3] = 6'(d);
    v.e0 = 6'(e0); v.e1 = 6'(e1);
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic [3:0] va, input logic [3:0][5:0] tg);
    flush    = fl;
    fu_valid = va;
    for (int f = 0; f < 4; f++) begin
      fu_tag[f]   = va[f] ? tg[f] : 6'd0;
      fu_value[f] = val_of(fu_tag[f]);
      fu_rob[f]   = rob_of(fu_tag[f]);
    end
  endtask

  task automatic sb_clear();
    for (int f = 0; f < 4; f++) sb_q[f].delete();
  endtask

  // Record results the bench expects to be accepted this cycle
  task automatic sb_push(input logic [3:0] exp_rd);
    res_t r;
    for (int f = 0; f < 4; f++) begin
      if (fu_valid[f] && exp_rd[f] && !flush) begin
        r.tag = fu_tag[f]; r.value = fu_value[f]; r.rob = fu_rob[f];
        sb_q[f].push_back(r);
        fu_of[int'(fu_tag[f])] = f;
      end
    end
  endtask

  task automatic check_cdb(input string ctx, input logic [1:0] ecv,
                           input logic [5:0] e0, input logic [5:0] e1);
    res_t exp_r;
    int   f;
    chk({ctx, " cdb_valid"}, 128'(cdb_valid), 128'(ecv));
    for (int k = 0; k < 2; k++) begin
      if (ecv[k]) chk($sformatf("%s lane%0d tag", ctx, k), 128'(cdb_tag[k]), 128'((k == 0) ? e0 : e1));
      else        chk($sformatf("%s lane%0d idle payload", ctx, k),
                      128'({cdb_tag[k], cdb_value[k], cdb_rob[k]}), 128'd0);
      if (cdb_valid[k]) begin
        if (fu_of.exists(int'(cdb_tag[k]))) f = fu_of[int'(cdb_tag[k])];
        else f = -1;
        if (f < 0 || sb_q[f].size() == 0) begin
          n_chk++;
          errs++;
          $display("FAIL %s lane%0d scoreboard: got unexpected tag 0x%0h, required no broadcast", ctx, k, cdb_tag[k]);
        end else begin
          exp_r = sb_q[f].pop_front();
          chk($sformatf("%s lane%0d payload", ctx, k),
              128'({cdb_tag[k], cdb_value[k], cdb_rob[k]}), 128'(exp_r));
        end
      end
    end
  endtask

  logic [3:0][5:0] tg_tmp;

  initial begin
    // flush, valid, FU0..FU3 tags, exp ready, exp cdb_valid, lane0 tag, lane1 tag
    vecs[0]  = mk(1'b0, 4'b0010,  0,  5,  0,  0, 4'b1111, 2'b00,  0,  0);
    vecs[1]  = mk(1'b0, 4'b0000,  0,  0,  0,  0, 4'b1111, 2'b01,  5,  0);
    vecs[2]  = mk(1'b0, 4'b0000,  0,  0,  0,  0, 4'b1111, 2'b00,  0,  0);
    vecs[3]  = mk(1'b1, 4'b0000,  0,  0,  0,  0, 4'b0000, 2'b00,  0,  0);
    vecs[4]  = mk(1'b0, 4'b1111, 10, 11, 12, 13, 4'b1111, 2'b00,  0,  0);
    vecs[5]  = mk(1'b0, 4'b0000,  0,  0,  0,  0, 4'b1111, 2'b11, 10, 11);
    vecs[6]  = mk(1'b0, 4'b0000,  0,  0,  0,  0, 4'b1111, 2'b11, 12, 13);
    vecs[7]  = mk(1'b0, 4'b0000,  0,  0,  0,  0, 4'b1111, 2'b00,  0,  0);
    vecs[8]  = mk(1'b0, 4'b0100,  0,  0, 20,  0, 4'b1111, 2'b00,  0,  0);
    vecs[9]  = mk(1'b0, 4'b1001, 21,  0,  0, 22, 4'b1111, 2'b01, 20,  0);
    vecs[10] = mk(1'b0, 4'b1001, 23,  0,  0, 24, 4'b1111, 2'b11, 22, 21);
    vecs[11] = mk(1'b0, 4'b1001, 25,  0,  0, 26, 4'b1111, 2'b11, 24, 23);
    vecs[12] = mk(1'b0, 4'b0000,  0,  0,  0,  0, 4'b1111, 2'b11, 26, 25);
    vecs[13] = mk(1'b0, 4'b0000,  0,  0,  0,  0, 4'b1111, 2'b00,  0,  0);
    vecs[14] = mk(1'b0, 4'b0111, 30, 31, 32,  0, 4'b1111, 2'b00,  0,  0);
    vecs[15] = mk(1'b0, 4'b0111, 33, 34, 35,  0, 4'b1111, 2'b11, 31, 32);
    vecs[16] = mk(1'b0, 4'b0111, 36, 37, 38,  0, 4'b1110, 2'b11, 30, 34);
    vecs[17] = mk(1'b0, 4'b0111, 36, 39, 40,  0, 4'b1011, 2'b11, 35, 33);
    vecs[18] = mk(1'b0, 4'b0110,  0, 41, 40,  0, 4'b1101, 2'b11, 37, 38);
    vecs[19] = mk(1'b0, 4'b0010,  0, 41,  0,  0, 4'b1111, 2'b11, 36, 39);
    vecs[20] = mk(1'b0, 4'b0000,  0,  0,  0,  0, 4'b1111, 2'b11, 40, 41);
    vecs[21] = mk(1'b0, 4'b0000,  0,  0,  0,  0, 4'b1111, 2'b00,  0,  0);
    vecs[22] = mk(1'b0, 4'b0111, 42, 43, 44,  0, 4'b1111, 2'b00,  0,  0);
    vecs[23] = mk(1'b0, 4'b1001, 46,  0,  0, 45, 4'b1111, 2'b11, 44, 42);
    vecs[24] = mk(1'b1, 4'b1111, 47, 48, 49, 50, 4'b0000, 2'b00,  0,  0);
    vecs[25] = mk(1'b0, 4'b0100,  0,  0, 51,  0, 4'b1111, 2'b00,  0,  0);
    vecs[26] = mk(1'b0, 4'b0000,  0,  0,  0,  0, 4'b1111, 2'b01, 51,  0);
    vecs[27] = mk(1'b0, 4'b0000,  0,  0,  0,  0, 4'b1111, 2'b00,  0,  0);

    reset = 1'b1;
    tg_tmp = '0;
    drive(1'b0, 4'b0000, tg_tmp);
    repeat (2) @(negedge clk);
    check_cdb("reset", 2'b00, 6'd0, 6'd0);
    chk("reset fu_ready", 128'(fu_ready), 128'(4'b1111));
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].fl, vecs[i].va, vecs[i].tg);
      #1;
      chk($sformatf("row%0d fu_ready", i), 128'(fu_ready), 128'(vecs[i].rd));
      if (vecs[i].fl) sb_clear();
      sb_push(vecs[i].rd);
      @(posedge clk);
      #1;
      check_cdb($sformatf("row%0d", i), vecs[i].cv, vecs[i].e0, vecs[i].e1);
    end

    // Reset while both lanes are broadcasting (rr_ptr is 3 here)
    @(negedge clk);
    tg_tmp[0] = 6'd52; tg_tmp[1] = 6'd53; tg_tmp[2] = 6'd54; tg_tmp[3] = 6'd55;
    drive(1'b0, 4'b1111, tg_tmp);
    #1;
    chk("rst_seq fu_ready", 128'(fu_ready), 128'(4'b1111));
    sb_push(4'b1111);
    @(posedge clk); #1;
    check_cdb("rst_seq fill", 2'b00, 6'd0, 6'd0);
    @(negedge clk);
    tg_tmp = '0;
    drive(1'b0, 4'b0000, tg_tmp);
    @(posedge clk); #1;
    check_cdb("rst_seq busy", 2'b11, 6'd55, 6'd52);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_cdb("rst_seq async", 2'b00, 6'd0, 6'd0);
    chk("rst_seq fu_ready", 128'(fu_ready), 128'(4'b1111));
    sb_clear();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check_cdb($sformatf("rst_seq idle%0d", c), 2'b00, 6'd0, 6'd0);
    end
    // Fresh result after reset: rr_ptr back at 0, lane0, two cycles later
    @(negedge clk);
    tg_tmp[1] = 6'd56;
    drive(1'b0, 4'b0010, tg_tmp);
    #1;
    chk("rst_seq new fu_ready", 128'(fu_ready), 128'(4'b1111));
    sb_push(4'b1111);
    @(posedge clk); #1;
    check_cdb("rst_seq new accept", 2'b00, 6'd0, 6'd0);
    @(negedge clk);
    tg_tmp = '0;
    drive(1'b0, 4'b0000, tg_tmp);
    @(posedge clk); #1;
    check_cdb("rst_seq new bcast", 2'b01, 6'd56, 6'd0);
    @(posedge clk); #1;
    check_cdb("rst_seq new done", 2'b00, 6'd0, 6'd0);

    for (int f = 0; f < 4; f++) begin
      chk($sformatf("fu%0d results left undelivered", f), 128'(sb_q[f].size()), 128'd0);
    end

    $display("Result: errors=%0d of %0d checks", errs, n_chk);
    $finish;
  end

endmodule
